wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
// - Write-side master of the 16-bit register file's single write port (we/wr_addr/wr_data).
// - Merges writeback results from the single-cycle ALU (port A) and the multi-cycle load/mul unit (port B).
// - Holds results in one skid slot per port and serialises them to one registered write per cycle.
// - Exports a pending-destination mask so decode can stall on registers not yet written.
// PARAMETERS
// - DATA_W    16  register width
// - ADDR_W    5   register index width (32 registers)
// - MAX_WAIT  4   max consecutive cycles a held B result may lose to A before B is forced
// PORTS
// - clk        in   1       single clock, posedge
// - rst        in   1       reset, asynchronous, active-high
// - a_valid    in   1       ALU result valid
// - a_ready    out  1       ALU result accepted when a_valid && a_ready at posedge
// - a_addr     in   ADDR_W  ALU destination register
// - a_data     in   DATA_W  ALU result
// - b_valid    in   1       load/mul result valid
// - b_ready    out  1       load/mul result accepted when b_valid && b_ready at posedge
// - b_addr     in   ADDR_W  load/mul destination register
// - b_data     in   DATA_W  load/mul result
// - we         out  1       register-file write enable (registered)
// - wr_addr    out  ADDR_W  register-file write address (registered)
// - wr_data    out  DATA_W  register-file write data (registered)
// - busy_mask  out  32      bit i = register i has a write not yet committed to the register file
// BEHAVIOUR
// - Reset: while rst=1 -> we=0, wr_addr=0, wr_data=0, both slots empty, wait counter=0, a_ready=b_ready=0, busy_mask=0.
// - Reset mid-operation discards held results; no write is emitted for them.
// - Accept: on valid&&ready, {addr,data} is captured into the port's slot at posedge.
// - addr==0 is accepted but never stored, never written, and never set in busy_mask.
// - ready = !rst && (slot empty || slot selected this cycle), giving full back-to-back throughput per port.
// - Select (combinational, one slot per cycle). Priority order:
//   1. Both held, same addr -> older slot wins. Age flag is set at capture; simultaneous capture -> B older.
//   2. B held and wait_cnt >= MAX_WAIT -> B.
//   3. A held -> A.
//   4. B held -> B.
// - Commit: at posedge, the selected slot drives we=1, wr_addr, wr_data, and the slot frees.
//   No selection -> we=0; wr_addr and wr_data hold their previous values.
// - Latency: capture at edge N, we=1 after edge N+1, register file updated at edge N+2.
// - wait_cnt: +1 each cycle B is held and not selected (saturates at MAX_WAIT); clears when B is selected or the B slot is empty.
// - Same-address ordering: the older value is written first and the younger next cycle, so the younger value is final.
// - busy_mask = held slot addrs OR (we ? wr_addr : none); bit 0 is always 0.
// STRUCTURE
// - rv16_pkg: XLEN=16, REG_ADDR_W=5, NUM_REGS=32, typedef struct packed {addr; data} wb_req_t.
// - Sub-module wb_hold_slot: one-entry skid buffer (valid, wb_req_t, age bit, accept/free). Instantiated twice.
// - Top level holds the arbiter, wait counter, output register and busy_mask logic.
// TESTING
// - Reset: hold A and B slots, assert rst asynchronously between edges
//   -> we=0 and busy_mask=0 immediately, ready=0 during reset, ready=1 on the first cycle after release.
// - Single port: A sends addr 3 / 0x1234 at edge 1 -> we=1, wr_addr=3, wr_data=0x1234 after edge 2.
//   Continuous A traffic -> we=1 every cycle, a_ready stays 1.
// - Fairness: A and B continuously valid with distinct addresses, MAX_WAIT=4 -> commit order A,A,A,A,B repeating.
//   b_ready pulses once per 5 cycles.
// - Same address: B captures r7=0xAAAA at edge 0, A captures r7=0xBBBB at edge 1
//   -> writes 0xAAAA then 0xBBBB. busy_mask[7]=1 from edge 0 until the cycle after the last write.
// - x0 drop: A sends addr 0 / 0xFFFF -> accepted (a_ready=1), we never asserts, busy_mask stays 0.

Source files
------------

// File: rtl/rv16_pkg.sv
// Shared types for the 16-bit core's writeback path.
// One request is a destination register plus the value to write.
package rv16_pkg;

   localparam int XLEN       = 16;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_A,
      SEL_B
   } wb_sel_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry skid slot for a writeback request.
// The young flag marks the entry captured after the other port's entry.
module wb_hold_slot
   import rv16_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    load,
   input  logic    free,
   input  logic    young_in,
   input  logic    clr_young,
   input  wb_req_t req_in,
   output logic    valid,
   output wb_req_t req,
   output logic    young
);

   logic    valid_q, valid_d;
   logic    young_q, young_d;
   wb_req_t req_q, req_d;

   always_comb begin
      valid_d = valid_q;
      young_d = young_q;
      req_d   = req_q;
      if (free) valid_d = 1'b0;
      if (clr_young) young_d = 1'b0;
      if (load) begin
         valid_d = 1'b1;
         young_d = young_in;
         req_d   = req_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         young_q <= 1'b0;
         req_q   <= '0;
      end else begin
         valid_q <= valid_d;
         young_q <= young_d;
         req_q   <= req_d;
      end
   end

   assign valid = valid_q;
   assign young = young_q;
   assign req   = req_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and load/mul writebacks onto the single register-file write port.
// One registered write per cycle; B is forced after MAX_WAIT consecutive losses.
module wb_write_arbiter
   import rv16_pkg::*;
#(
   parameter int DATA_W   = XLEN,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_data,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_data,
   output logic                we,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [NUM_REGS-1:0] busy_mask
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   logic    a_held, b_held, a_young, b_young;
   wb_req_t a_req, b_req;
   logic    a_load, b_load, a_stay, b_stay;
   wb_sel_e sel;

   logic [WW-1:0]     wait_q, wait_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   // x0 writes are accepted but never occupy a slot
   assign a_load = a_valid && a_ready && (a_addr != '0);
   assign b_load = b_valid && b_ready && (b_addr != '0);
   assign a_stay = a_held && (sel != SEL_A);
   assign b_stay = b_held && (sel != SEL_B);

   assign a_ready = !rst && (!a_held || sel == SEL_A);
   assign b_ready = !rst && (!b_held || sel == SEL_B);

   wb_hold_slot u_slot_a (
      .clk       (clk),
      .rst       (rst),
      .load      (a_load),
      .free      (sel == SEL_A),
      .young_in  (b_stay || b_load),
      .clr_young (!b_stay),
      .req_in    ('{addr: a_addr, data: a_data}),
      .valid     (a_held),
      .req       (a_req),
      .young     (a_young)
   );

   wb_hold_slot u_slot_b (
      .clk       (clk),
      .rst       (rst),
      .load      (b_load),
      .free      (sel == SEL_B),
      .young_in  (a_stay),
      .clr_young (!a_stay),
      .req_in    ('{addr: b_addr, data: b_data}),
      .valid     (b_held),
      .req       (b_req),
      .young     (b_young)
   );

   always_comb begin
      sel = SEL_NONE;
      if (a_held && b_held && a_req.addr == b_req.addr)
         sel = a_young ? SEL_B : SEL_A;
      else if (b_held && wait_q >= WW'(MAX_WAIT))
         sel = SEL_B;
      else if (a_held)
         sel = SEL_A;
      else if (b_held)
         sel = SEL_B;
   end

   always_comb begin
      wait_d = '0;
      if (b_held && sel != SEL_B)
         wait_d = (wait_q < WW'(MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
   end

   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      unique case (sel)
         SEL_A: begin
            we_d   = 1'b1;
            addr_d = a_req.addr;
            data_d = a_req.data;
         end
         SEL_B: begin
            we_d   = 1'b1;
            addr_d = b_req.addr;
            data_d = b_req.data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         wait_q <= wait_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign we      = we_q;
   assign wr_addr = addr_q;
   assign wr_data = data_q;

   always_comb begin
      busy_mask = '0;
      if (a_held) busy_mask[a_req.addr] = 1'b1;
      if (b_held) busy_mask[b_req.addr] = 1'b1;
      if (we_q) busy_mask[addr_q] = 1'b1;
      busy_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic
// against a timestamp-ordered reference model.
module tb_wb_write_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [15:0] a_data, b_data;
   logic        we;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic [31:0] busy_mask;

   wb_write_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_mask (busy_mask)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: pending entries ordered by capture timestamp
   logic        ma_h, mb_h;
   logic [4:0]  ma_addr, mb_addr;
   logic [15:0] ma_data, mb_data;
   int          ma_st, mb_st;
   int          mwait;
   logic        mwe;
   logic [4:0]  mwa;
   logic [15:0] mwd;

   logic        obs_ar, obs_br, obs_we;
   logic [4:0]  obs_wa;
   logic [15:0] obs_wd;
   logic [31:0] obs_busy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      ma_h = 0; mb_h = 0; mwait = 0;
      mwe = 0; mwa = '0; mwd = '0;
      ma_addr = '0; mb_addr = '0; ma_data = '0; mb_data = '0;
      ma_st = 0; mb_st = 0;
   endtask

   task automatic step(input logic av, input logic [4:0] aa,
                       input logic [15:0] ad, input logic bv,
                       input logic [4:0] ba, input logic [15:0] bd);
      int sel;
      logic ear, ebr;
      logic [31:0] ebusy;
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      @(negedge clk);
      sel = 0;
      if (ma_h && mb_h && ma_addr == mb_addr)
         sel = (ma_st < mb_st) ? 1 : 2;
      else if (mb_h && mwait >= MAXW) sel = 2;
      else if (ma_h) sel = 1;
      else if (mb_h) sel = 2;
      ear = !ma_h || sel == 1;
      ebr = !mb_h || sel == 2;
      ebusy = '0;
      if (ma_h) ebusy[ma_addr] = 1'b1;
      if (mb_h) ebusy[mb_addr] = 1'b1;
      if (mwe) ebusy[mwa] = 1'b1;
      ebusy[0] = 1'b0;
      chk("a_ready", a_ready, ear);
      chk("b_ready", b_ready, ebr);
      chk("we", we, mwe);
      if (mwe) begin
         chk("wr_addr", wr_addr, mwa);
         chk("wr_data", wr_data, mwd);
      end
      chk("busy_mask", busy_mask, ebusy);
      obs_ar = a_ready; obs_br = b_ready; obs_we = we;
      obs_wa = wr_addr; obs_wd = wr_data; obs_busy = busy_mask;
      @(posedge clk);
      mwe = (sel != 0);
      if (sel == 1) begin mwa = ma_addr; mwd = ma_data; end
      if (sel == 2) begin mwa = mb_addr; mwd = mb_data; end
      if (mb_h && sel != 2) mwait = (mwait < MAXW) ? mwait + 1 : MAXW;
      else mwait = 0;
      if (sel == 1) ma_h = 0;
      if (sel == 2) mb_h = 0;
      if (av && ear && aa != 0) begin
         ma_h = 1; ma_addr = aa; ma_data = ad; ma_st = 2 * cyc + 1;
      end
      if (bv && ebr && ba != 0) begin
         mb_h = 1; mb_addr = ba; mb_data = bd; mb_st = 2 * cyc;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int cnt, cnt2;
      logic [4:0] ra, rb;
      rst = 1'b1;
      a_valid = 0; b_valid = 0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", we, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      rst = 1'b0;

      // single write latency
      step(1, 5'd3, 16'h1234, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("single_we", obs_we, 1);
      chk("single_addr", obs_wa, 3);
      chk("single_data", obs_wd, 16'h1234);
      idle(1);

      // continuous A traffic
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 5'($urandom_range(1, 31)), 16'($urandom), 0, 0, 0);
         if (obs_ar) cnt++;
         if (i >= 2 && obs_we) cnt2++;
      end
      chk("a_stream_ready", cnt, 12);
      chk("a_stream_we", cnt2, 10);
      idle(3);

      // same-address ordering
      step(0, 0, 0, 1, 5'd7, 16'hAAAA);
      step(1, 5'd7, 16'hBBBB, 0, 0, 0);
      chk("same_busy7_0", obs_busy[7], 1);
      step(0, 0, 0, 0, 0, 0);
      chk("same_first", obs_wd, 16'hAAAA);
      chk("same_busy7_1", obs_busy[7], 1);
      step(0, 0, 0, 0, 0, 0);
      chk("same_second", obs_wd, 16'hBBBB);
      chk("same_we2", obs_we, 1);
      chk("same_busy7_2", obs_busy[7], 1);
      step(0, 0, 0, 0, 0, 0);
      chk("same_busy7_3", obs_busy[7], 0);
      idle(2);

      // x0 drop
      step(1, 5'd0, 16'hFFFF, 0, 0, 0);
      chk("x0_ready", obs_ar, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("x0_busy", obs_busy, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("x0_we", obs_we, 0);

      // fairness: A,A,A,A,B
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 25; i++) begin
         step(1, 5'($urandom_range(1, 15)), 16'($urandom),
              1, 5'($urandom_range(16, 31)), 16'($urandom));
         if (obs_br) cnt++;
         if (obs_ar) cnt2++;
      end
      chk("fair_b_pulses", cnt, 5);
      chk("fair_a_ready", cnt2, 21);
      idle(4);

      // asynchronous reset with a write in flight and B held
      step(1, 5'd5, 16'h5555, 1, 5'd6, 16'h6666);
      step(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_we", we, 0);
      chk("arst_busy", busy_mask, 0);
      chk("arst_a_ready", a_ready, 0);
      chk("arst_b_ready", b_ready, 0);
      mreset();
      @(posedge clk);
      #1;
      chk("arst_hold_ready", a_ready, 0);
      rst = 1'b0;
      #1;
      chk("rel_a_ready", a_ready, 1);
      chk("rel_b_ready", b_ready, 1);
      idle(3);

      // random traffic with frequent address collisions
      for (int i = 0; i < 400; i++) begin
         ra = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3))
                                          : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3))
                                          : 5'($urandom_range(0, 31));
         step($urandom_range(0, 9) < 7, ra, 16'($urandom),
              $urandom_range(0, 9) < 6, rb, 16'($urandom));
      end
      idle(6);
      chk("drain_busy", obs_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
